// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Interlock and sequencing controller for a five-stage pipeline with no
// forwarding, register-file write in WB and NPC resolved in WB. A 3-slot
// scoreboard (EX, MEM, WB) tracks in-flight instructions. RAW hazards stall
// in ID. Control-flow instructions drain the pipeline before fetch resumes
// at the WB-computed target.
//
// Ports:
//   clk, rst          pipeline clock, synchronous active-high reset
//   id_valid          ID holds a real instruction
//   id_rs/id_rt       source register fields, id_use_rs/id_use_rt qualify them
//   id_wr_en/id_wr_reg destination write enable and resolved destination
//   id_is_ctrl        ID instruction changes NPC
//   pc_en, if_id_en   PC and IF/ID load enables
//   if_id_flush       IF/ID captures a bubble (wins over if_id_en)
//   id_ex_bubble      ID/EX captures a bubble
//   stall_cnt         saturating count of RAW-stall cycles
//   flush_cnt         saturating count of flush cycles outside reset

module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr_en,
    input  logic [4:0]       id_wr_reg,
    input  logic             id_is_ctrl,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic       v;
        logic       wr;
        logic [4:0] rd;
        logic       ctrl;
    } slot_t;

    slot_t ex_q, mem_q, wb_q, ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic raw_hz, ctrl_busy, issue, ctrl_issue, wb_redirect;
    logic pc_en_n, flush_n;

    // r0 is hardwired, so a write to it never creates a dependence.
    function automatic logic slot_hit(input slot_t s, input logic [4:0] r);
        return s.v && s.wr && (s.rd == r) && (r != 5'd0);
    endfunction

    always_comb begin
        // WB still counts: the register file has no write-through.
        raw_hz = id_valid &&
                 ((id_use_rs && (slot_hit(ex_q, id_rs) || slot_hit(mem_q, id_rs) ||
                                 slot_hit(wb_q, id_rs))) ||
                  (id_use_rt && (slot_hit(ex_q, id_rt) || slot_hit(mem_q, id_rt) ||
                                 slot_hit(wb_q, id_rt))));
        ctrl_busy   = (ex_q.v && ex_q.ctrl) || (mem_q.v && mem_q.ctrl) ||
                      (wb_q.v && wb_q.ctrl);
        issue       = id_valid && !raw_hz && !ctrl_busy;
        ctrl_issue  = issue && id_is_ctrl;
        wb_redirect = wb_q.v && wb_q.ctrl;

        // While a control instruction drains, ID is wrong-path, so its RAW
        // state is irrelevant; the WB redirect reopens fetch for the target.
        pc_en_n = (!raw_hz && !ctrl_issue && !ctrl_busy) || wb_redirect;
        flush_n = ctrl_issue || ctrl_busy;

        ex_d = '0;
        if (issue) begin
            ex_d.v    = 1'b1;
            ex_d.wr   = id_wr_en;
            ex_d.rd   = id_wr_reg;
            ex_d.ctrl = id_is_ctrl;
        end

        stall_cnt_d = stall_cnt_q;
        if (raw_hz && !ctrl_busy && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);

        flush_cnt_d = flush_cnt_q;
        if (flush_n && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);

        pc_en        = !rst && pc_en_n;
        if_id_en     = !rst && pc_en_n;
        if_id_flush  = rst || flush_n;
        id_ex_bubble = rst || !issue;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus a randomized phase, all
// checked against a timestamp model of issued instructions.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       we;
        logic [4:0] wd;
        logic       ctl;
    } id_t;

    typedef struct {
        int         t;
        logic       wr;
        logic [4:0] rd;
        logic       ctl;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_ctrl;
    logic [4:0]       id_rs, id_rt, id_wr_reg;
    logic             pc_en, if_id_en, if_id_flush, id_ex_bubble;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
        .id_wr_reg(id_wr_reg), .id_is_ctrl(id_is_ctrl), .pc_en(pc_en),
        .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Model state: issued instructions with their issue cycle.
    int   cyc = 0;
    rec_t q[$];
    int   m_stall = 0;
    int   m_flush = 0;

    // Last observed outputs, for directed constant checks.
    logic o_pc, o_flush, o_bub;
    int   o_stall, o_fcnt;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic id_t mk(input logic v, input int rs, input int rt,
                               input logic urs, input logic urt, input logic we,
                               input int wd, input logic ctl);
        id_t x;
        x.v = v; x.rs = 5'(rs); x.rt = 5'(rt); x.urs = urs; x.urt = urt;
        x.we = we; x.wd = 5'(wd); x.ctl = ctl;
        return x;
    endfunction

    // One pipeline cycle: drive, check against model, advance model.
    task automatic step(input logic r, input id_t x);
        logic hit, busy, redir, raw, iss, e_pc, e_fl, e_bub;
        int age;
        @(negedge clk);
        rst = r; id_valid = x.v; id_rs = x.rs; id_rt = x.rt;
        id_use_rs = x.urs; id_use_rt = x.urt; id_wr_en = x.we;
        id_wr_reg = x.wd; id_is_ctrl = x.ctl;
        #1;
        hit = 0; busy = 0; redir = 0;
        foreach (q[i]) begin
            age = cyc - q[i].t;
            if (age >= 1 && age <= 3) begin
                if (q[i].wr && q[i].rd != 0) begin
                    if (x.urs && q[i].rd == x.rs) hit = 1;
                    if (x.urt && q[i].rd == x.rt) hit = 1;
                end
                if (q[i].ctl) busy = 1;
                if (q[i].ctl && age == 3) redir = 1;
            end
        end
        raw = x.v && hit;
        iss = x.v && !raw && !busy;
        if (r) begin
            e_pc = 0; e_fl = 1; e_bub = 1;
        end else begin
            e_pc  = (!raw && !(iss && x.ctl) && !busy) || redir;
            e_fl  = (iss && x.ctl) || busy;
            e_bub = !iss;
        end
        chk("pc_en", int'(pc_en), int'(e_pc));
        chk("if_id_en", int'(if_id_en), int'(e_pc));
        chk("if_id_flush", int'(if_id_flush), int'(e_fl));
        chk("id_ex_bubble", int'(id_ex_bubble), int'(e_bub));
        chk("stall_cnt", int'(stall_cnt), m_stall);
        chk("flush_cnt", int'(flush_cnt), m_flush);
        o_pc = pc_en; o_flush = if_id_flush; o_bub = id_ex_bubble;
        o_stall = int'(stall_cnt); o_fcnt = int'(flush_cnt);
        if (r) begin
            q.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (iss) q.push_back('{t: cyc, wr: x.we, rd: x.wd, ctl: x.ctl});
            if (raw && !busy && m_stall < CMAX) m_stall++;
            if (e_fl && m_flush < CMAX) m_flush++;
        end
        while (q.size() > 0 && (cyc - q[0].t) >= 3) void'(q.pop_front());
        cyc++;
    endtask

    id_t idle;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1; id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_wr_en = 0; id_wr_reg = 0; id_is_ctrl = 0;

        // Reset then an independent stream.
        step(1, idle);
        chk("rst_pc", int'(o_pc), 0);
        chk("rst_flush", int'(o_flush), 1);
        step(1, idle);
        for (int i = 0; i < 6; i++) begin
            step(0, mk(1, 20, 21, 1, 1, 1, 10 + i, 0));
            chk("ind_pc", int'(o_pc), 1);
            chk("ind_bub", int'(o_bub), 0);
        end
        step(0, idle);
        chk("ind_stall", o_stall, 0);

        // Load-use: lw r1 then add r2,r1,r3.
        step(1, idle);
        step(0, mk(1, 5, 0, 1, 0, 1, 1, 0));
        for (int i = 1; i <= 3; i++) begin
            step(0, mk(1, 1, 3, 1, 1, 1, 2, 0));
            chk("lu_bub", int'(o_bub), 1);
            chk("lu_pc", int'(o_pc), 0);
        end
        step(0, mk(1, 1, 3, 1, 1, 1, 2, 0));
        chk("lu_issue", int'(o_bub), 0);
        step(0, idle);
        chk("lu_stall", o_stall, 3);

        // r0 writer and non-writer produce no stall.
        step(1, idle);
        step(0, mk(1, 0, 0, 0, 0, 1, 0, 0));
        step(0, mk(1, 0, 0, 1, 0, 1, 6, 0));
        chk("r0_bub", int'(o_bub), 0);
        step(0, mk(1, 0, 0, 0, 0, 0, 1, 0));
        step(0, mk(1, 1, 1, 1, 1, 1, 7, 0));
        chk("nw_bub", int'(o_bub), 0);
        step(0, idle);
        chk("r0_stall", o_stall, 0);

        // Branch redirect.
        step(1, idle);
        step(0, mk(1, 0, 0, 1, 1, 0, 0, 1));
        chk("br_t_flush", int'(o_flush), 1);
        chk("br_t_pc", int'(o_pc), 0);
        for (int i = 1; i <= 2; i++) begin
            step(0, mk(1, 9, 9, 1, 1, 1, 9, 0));
            chk("br_wp_flush", int'(o_flush), 1);
            chk("br_wp_pc", int'(o_pc), 0);
            chk("br_wp_bub", int'(o_bub), 1);
        end
        step(0, mk(1, 9, 9, 1, 1, 1, 9, 0));
        chk("br_t3_pc", int'(o_pc), 1);
        chk("br_t3_flush", int'(o_flush), 1);
        step(0, idle);
        chk("br_t4_flush", int'(o_flush), 0);
        chk("br_fcnt", o_fcnt, 4);
        step(0, mk(1, 2, 2, 1, 1, 1, 3, 0));
        chk("br_tgt_bub", int'(o_bub), 0);

        // RAW hazard on a branch.
        step(1, idle);
        step(0, mk(1, 0, 0, 0, 0, 1, 4, 0));
        for (int i = 0; i < 4; i++) step(0, mk(1, 4, 0, 1, 1, 0, 0, 1));
        for (int i = 0; i < 4; i++) step(0, idle);
        chk("rb_stall", o_stall, 3);
        chk("rb_fcnt", o_fcnt, 4);

        // Reset in the middle of a redirect.
        step(1, idle);
        step(0, mk(1, 0, 0, 0, 0, 0, 0, 1));
        step(0, idle);
        step(1, idle);
        chk("mr_rst_pc", int'(o_pc), 0);
        step(0, mk(1, 3, 3, 1, 1, 1, 3, 0));
        chk("mr_pc", int'(o_pc), 1);
        chk("mr_flush", int'(o_flush), 0);
        chk("mr_bub", int'(o_bub), 0);
        chk("mr_stall", o_stall, 0);
        chk("mr_fcnt", o_fcnt, 0);

        // Randomized phase with small register range; long enough to saturate.
        for (int i = 0; i < 600; i++) begin
            id_t x;
            x = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 7) == 0);
            step(($urandom_range(0, 79) == 0), x);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline interlock and sequencing controller for the five-stage MIPS datapath. The pipeline has no forwarding, writes the register file in WB and resolves NPC in WB. This block keeps a 3-slot scoreboard of the instructions in flight in EX, MEM and WB. From it, the block generates the PC enable, the IF/ID enable and flush, and the ID/EX bubble, so that:
- RAW hazards stall in ID;
- control-flow instructions drain the pipeline before fetch resumes at the WB-computed target.

## Interface
Parameters:
- CNT_W, 32, width of the stall and flush performance counters

Ports:
- clk  in  1  pipeline clock; single clock domain
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  the ID stage holds a real (non-bubble) instruction
- id_rs  in  5  rs field of the ID instruction
- id_rt  in  5  rt field of the ID instruction
- id_use_rs  in  1  the ID instruction reads rs
- id_use_rt  in  1  the ID instruction reads rt
- id_wr_en  in  1  the ID instruction writes the register file (RegWr)
- id_wr_reg  in  5  destination register, already resolved from RegDst (Rd or Rt)
- id_is_ctrl  in  1  the ID instruction changes NPC (branch or jump; NPCop non-sequential)
- pc_en  out  1  PC register load enable
- if_id_en  out  1  IF/ID register load enable
- if_id_flush  out  1  IF/ID captures a bubble; has priority over if_id_en
- id_ex_bubble  out  1  ID/EX captures a bubble; all write and control enables are zeroed
- stall_cnt  out  CNT_W  number of cycles with a RAW stall, saturating
- flush_cnt  out  CNT_W  number of cycles with if_id_flush high outside reset, saturating

## Operation
Scoreboard:
- Three slots: EX, MEM, WB. Each slot holds {v, wr, reg[4:0], ctrl}.
- Every clock the slots shift: WB <= MEM, MEM <= EX.
- EX <= {1, id_wr_en, id_wr_reg, id_is_ctrl} when the instruction issues; otherwise EX <= all-zero.
- Issue condition: issue = id_valid & !raw_hz & !ctrl_busy.

Hazard terms (all combinational):
- A slot matches register x when v & wr & reg == x & x != 0.
- raw_hz = id_valid & ((id_use_rs & any slot matches id_rs) | (id_use_rt & any slot matches id_rt)).
- The WB slot counts as a match because the register file has no write-through.
- ctrl_busy = (EX.v & EX.ctrl) | (MEM.v & MEM.ctrl) | (WB.v & WB.ctrl).
- ctrl_issue = issue & id_is_ctrl.
- wb_redirect = WB.v & WB.ctrl.

Outputs (combinational, valid when rst is low):
- pc_en = (!raw_hz & !ctrl_issue & !ctrl_busy) | wb_redirect
- if_id_en = pc_en
- if_id_flush = ctrl_issue | ctrl_busy
- id_ex_bubble = !issue

Priority and boundary rules:
- A control instruction with a RAW hazard stalls like any other instruction. It becomes ctrl_issue only on the cycle it issues.
- While ctrl_busy, the ID contents are wrong-path and are discarded: a bubble is issued and IF/ID is flushed. raw_hz is ignored for pc_en in that cycle.
- Register 0 never causes a hazard, even when wr=1.
- A slot with v=0 or wr=0 never matches.
- Back-to-back control instructions cannot occur: the second one is flushed.

Counters:
- stall_cnt increments on cycles where raw_hz & !ctrl_busy.
- flush_cnt increments on cycles where if_id_flush.
- Both saturate at all-ones and never wrap.

Reset:
- Reset takes effect on the rising edge with rst=1 and overrides everything else.
- It clears all slots and both counters, including when applied mid-stall or mid-redirect.
- While rst=1, the outputs are forced to pc_en=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1.
- In the first cycle after reset the outputs are pc_en=1, if_id_en=1, if_id_flush=0, and id_ex_bubble=!id_valid.

## Timing
- Zero-cycle decision: all enables are combinational from the current-cycle ID inputs and the registered slots. Only the slots and counters are registers.
- RAW stall: a producer issued in cycle t blocks a dependent ID instruction through cycle t+3. The dependent instruction issues at t+4 (3 stall cycles).
- With one independent instruction in between, the dependent instruction sees 2 stall cycles.
- Redirect: a control instruction issuing in cycle t reaches EX at t+1, MEM at t+2 and WB at t+3.
- PC loads NPC at the end of t+3 and the target instruction is in ID at t+5.
- if_id_flush is high in cycles t through t+3.
- Counters update at the clock edge following the counted cycle.

## Test plan
- Reset then independent stream: rst for 2 cycles, then 6 instructions with no dependences. During reset, pc_en=0 and if_id_flush=1. After reset, pc_en=1 every cycle, id_ex_bubble=0, stall_cnt=0.
- Load-use RAW: lw r1 issues at t, then add r2,r1,r3 sits in ID. id_ex_bubble=1 and pc_en=0 for t+1 to t+3; the add issues at t+4; stall_cnt=3.
- r0 and non-writer: the producer writes r0, or has wr=0 (sw) with reg=1, followed by a reader of the same register. No stall occurs and stall_cnt stays 0.
- Branch: beq issues at t. if_id_flush=1 for t to t+3, pc_en=0 for t to t+2, pc_en=1 at t+3, and the target is in ID at t+5 with id_valid=1. flush_cnt=4.
- RAW on a branch: lw r4 then beq r4,r0 in ID. The branch stalls 3 cycles, then follows the redirect sequence; stall_cnt=3, flush_cnt=4.
- Reset mid-redirect: assert rst at t+2 of a branch. All slots clear; in the first post-reset cycle pc_en=1 and if_id_flush=0, and both counters read 0.
